fifo_burst_reader: RTL and testbench

//  Read-side consumer of the FWFT FIFO (fifo_bh_ww32d16_rw32d16 class). On a start pulse
//  (host trigger), pops exactly burst_len words and forwards them to a valid/ready sink
//  (host pipe-out or packer) with m_last on the final word.

---
 rtl/fifo_rd_pkg.sv | 20 ++
 rtl/fifo_burst_reader_if.sv | 38 +++
 rtl/fifo_rd_out_stage.sv | 35 +++
 rtl/fifo_burst_reader.sv | 150 +++++++++++++++
 tb/tb_fifo_burst_reader.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_rd_pkg.sv
// Shared types and defaults for the FWFT FIFO burst reader.
package fifo_rd_pkg;

    localparam int DATA_W_DEF      = 32;
    localparam int LEN_W_DEF       = 16;
    localparam int TIMEOUT_CYC_DEF = 1024;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } rd_state_t;

    // Width of a counter that must reach timeout_cyc without wrapping.
    function automatic int stall_width(input int timeout_cyc);
        return $clog2(timeout_cyc + 1);
    endfunction

endpackage

// File: rtl/fifo_burst_reader_if.sv
// FIFO read port plus valid/ready sink stream seen by the burst reader.
// The master side is the reader; the slave side is the FIFO and the sink.
interface fifo_burst_reader_if
    import fifo_rd_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);

    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_dout;
    logic              fifo_rd_en;

    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_last;
    logic              m_ready;

    modport master (
        input  fifo_empty,
        input  fifo_dout,
        input  m_ready,
        output fifo_rd_en,
        output m_data,
        output m_valid,
        output m_last
    );

    modport slave (
        output fifo_empty,
        output fifo_dout,
        output m_ready,
        input  fifo_rd_en,
        input  m_data,
        input  m_valid,
        input  m_last
    );

endinterface

// File: rtl/fifo_rd_out_stage.sv
// One-entry output register between the FIFO head and the sink.
// A load always wins; an accepted beat with no load empties the register.
module fifo_rd_out_stage
    import fifo_rd_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    input  logic              ready,
    output logic [DATA_W-1:0] data,
    output logic              valid,
    output logic              last
);

    // Capture a popped word, or retire the held word once the sink takes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            data  <= '0;
            valid <= 1'b0;
            last  <= 1'b0;
        end else if (load) begin
            data  <= load_data;
            valid <= 1'b1;
            last  <= load_last;
        end else if (valid && ready) begin
            valid <= 1'b0;
            last  <= 1'b0;
        end
    end

endmodule

// File: rtl/fifo_burst_reader.sv
// Burst reader: on start, pops burst_len words from an FWFT FIFO and forwards
// them to a valid/ready sink, tagging the final word. Tracks beats delivered
// and their running sum, and aborts the burst if the FIFO starves too long.
module fifo_burst_reader
    import fifo_rd_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int LEN_W       = LEN_W_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [LEN_W-1:0]     burst_len,
    fifo_burst_reader_if.master  bus,
    output logic                 busy,
    output logic                 done,
    output logic                 timeout,
    output logic [LEN_W-1:0]     word_count,
    output logic [DATA_W-1:0]    data_sum
);

    localparam int               STALL_W     = stall_width(TIMEOUT_CYC);
    localparam logic [STALL_W-1:0] STALL_LIMIT = STALL_W'(TIMEOUT_CYC - 1);
    localparam logic [STALL_W-1:0] STALL_ONE   = STALL_W'(1);
    localparam logic [LEN_W-1:0]   LEN_ONE     = LEN_W'(1);

    rd_state_t          state;
    rd_state_t          next_state;
    logic [LEN_W-1:0]   remaining;
    logic [STALL_W-1:0] stall_cnt;
    logic               pop;
    logic               beat;
    logic               start_ok;
    logic               timeout_hit;
    logic [DATA_W-1:0]  out_data;
    logic               out_valid;
    logic               out_last;

    // Reset is folded into the pop strobe so a reset cycle never consumes a
    // word the reader is about to discard.
    assign pop  = !rst && (state == RUN) && !bus.fifo_empty &&
                  (remaining != '0) && (!out_valid || bus.m_ready);
    assign beat = out_valid && bus.m_ready;

    assign bus.fifo_rd_en = pop;
    assign bus.m_data     = out_data;
    assign bus.m_valid    = out_valid;
    assign bus.m_last     = out_last;

    fifo_rd_out_stage #(
        .DATA_W (DATA_W)
    ) u_out_stage (
        .clk       (clk),
        .rst       (rst),
        .load      (pop),
        .load_data (bus.fifo_dout),
        .load_last (remaining == LEN_ONE),
        .ready     (bus.m_ready),
        .data      (out_data),
        .valid     (out_valid),
        .last      (out_last)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode and state-derived status outputs.
    always_comb begin
        next_state  = state;
        busy        = 1'b0;
        done        = 1'b0;
        start_ok    = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    start_ok   = 1'b1;
                    next_state = (burst_len != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (pop && (remaining == LEN_ONE)) begin
                    next_state = DRAIN;
                end else if (bus.fifo_empty && (stall_cnt == STALL_LIMIT)) begin
                    timeout_hit = 1'b1;
                    next_state  = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (!out_valid || bus.m_ready) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Burst bookkeeping: words left to pop, beats delivered, sum, abort flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            remaining  <= '0;
            word_count <= '0;
            data_sum   <= '0;
            timeout    <= 1'b0;
        end else if (start_ok) begin
            remaining  <= burst_len;
            word_count <= '0;
            data_sum   <= '0;
            timeout    <= 1'b0;
        end else begin
            if (pop) begin
                remaining <= remaining - LEN_ONE;
            end
            if (beat) begin
                word_count <= word_count + LEN_ONE;
                data_sum   <= data_sum + out_data;
            end
            if (timeout_hit) begin
                timeout <= 1'b1;
            end
        end
    end

    // Consecutive starved cycles while running; any pop restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if ((state != RUN) || pop) begin
            stall_cnt <= '0;
        end else if (bus.fifo_empty) begin
            stall_cnt <= stall_cnt + STALL_ONE;
        end
    end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Scoreboard bench for fifo_burst_reader: stimulus queues expected beats and
// burst results; a negedge monitor compares them as the DUT produces them.
module tb_fifo_burst_reader;
    import fifo_rd_pkg::*;

    localparam int DATA_W      = 32;
    localparam int LEN_W       = 16;
    localparam int TIMEOUT_CYC = 64;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              last;
    } beat_t;

    typedef struct {
        int                word_count;
        logic [DATA_W-1:0] sum;
        logic              timeout;
        int                latency;
        int                limit;
    } end_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [LEN_W-1:0]  burst_len;
    logic              busy;
    logic              done;
    logic              timeout;
    logic [LEN_W-1:0]  word_count;
    logic [DATA_W-1:0] data_sum;

    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] fifo_q[$];
    int                ready_mode;
    logic              ready_tog = 1'b1;
    logic              rst_sampled = 1'b0;
    logic              tb_finished = 1'b0;
    logic              mon_closed = 1'b0;
    int                end_age = 0;
    int                check_count = 0;
    int                error_count = 0;

    beat_t exp_beats[$];
    end_t  exp_ends[$];

    fifo_burst_reader_if #(.DATA_W(DATA_W)) bus ();

    fifo_burst_reader #(
        .DATA_W      (DATA_W),
        .LEN_W       (LEN_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .burst_len  (burst_len),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .timeout    (timeout),
        .word_count (word_count),
        .data_sum   (data_sum)
    );

    always #5 clk = ~clk;

    // FWFT FIFO model: pop on rd_en, push on wr_en, head visible after the edge.
    always @(posedge clk) begin
        if (bus.fifo_rd_en && (fifo_q.size() != 0)) void'(fifo_q.pop_front());
        if (wr_en) fifo_q.push_back(wr_data);
        bus.fifo_empty <= (fifo_q.size() == 0);
        bus.fifo_dout  <= (fifo_q.size() != 0) ? fifo_q[0] : '0;
    end

    // Sink ready: held high, or alternating 1,0 when ready_mode is 1.
    always @(posedge clk) begin
        #1;
        if (ready_mode == 1) begin
            bus.m_ready = ready_tog;
            ready_tog   = ~ready_tog;
        end else begin
            bus.m_ready = 1'b1;
            ready_tog   = 1'b1;
        end
    end

    // Remember whether the last edge was a reset edge.
    always @(posedge clk) rst_sampled <= rst;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    // Monitor: reset state, beats against the scoreboard, burst results on done.
    always @(negedge clk) begin : monitor
        beat_t b;
        end_t  e;
        if (rst_sampled) begin
            checkOutput("reset_m_valid", bus.m_valid, 0);
            checkOutput("reset_m_data", bus.m_data, 0);
            checkOutput("reset_m_last", bus.m_last, 0);
            checkOutput("reset_busy", busy, 0);
            checkOutput("reset_done", done, 0);
            checkOutput("reset_timeout", timeout, 0);
            checkOutput("reset_word_count", word_count, 0);
            checkOutput("reset_data_sum", data_sum, 0);
            checkOutput("reset_rd_en", bus.fifo_rd_en, 0);
        end
        if (bus.fifo_rd_en) begin
            checkOutput("rd_en_while_empty", bus.fifo_empty, 0);
            checkOutput("rd_en_while_stalled", bus.m_valid && !bus.m_ready, 0);
        end
        if (!rst && bus.m_valid && bus.m_ready) begin
            if (exp_beats.size() == 0) begin
                check_count++;
                error_count++;
                $display("[TB] FAIL unexpected_beat actual=%0h required=none", bus.m_data);
            end else begin
                b = exp_beats.pop_front();
                checkOutput("beat_data", bus.m_data, b.data);
                checkOutput("beat_last", bus.m_last, b.last);
            end
        end
        if (exp_ends.size() != 0) begin
            end_age++;
            if (done) begin
                e = exp_ends.pop_front();
                checkOutput("end_word_count", word_count, e.word_count);
                checkOutput("end_data_sum", data_sum, e.sum);
                checkOutput("end_timeout", timeout, e.timeout);
                if (e.latency != 0) checkOutput("done_latency", end_age, e.latency);
                end_age = 0;
            end else if (end_age > exp_ends[0].limit) begin
                check_count++;
                error_count++;
                $display("[TB] FAIL done_missing actual=no_done_in_%0d required=done",
                         exp_ends[0].limit);
                void'(exp_ends.pop_front());
                end_age = 0;
            end
        end else if (done) begin
            check_count++;
            error_count++;
            $display("[TB] FAIL unexpected_done actual=1 required=0");
        end
        if (tb_finished && !mon_closed) begin
            mon_closed = 1'b1;
            checkOutput("leftover_beats", exp_beats.size(), 0);
            checkOutput("leftover_ends", exp_ends.size(), 0);
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic loadWords(input int base, input int n);
        for (int i = 0; i < n; i++) begin
            wr_en   = 1'b1;
            wr_data = DATA_W'(base + i);
            cyc(1);
        end
        wr_en = 1'b0;
        cyc(1);
    endtask

    task automatic pushBeats(input int base, input int n, input bit last_on_final);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.data = DATA_W'(base + i);
            b.last = last_on_final && (i == n - 1);
            exp_beats.push_back(b);
        end
    endtask

    // Queue the burst result (if one is expected) and pulse start.
    task automatic applyStimulus(input int len, input bit expect_end, input int wc,
                                 input int sum, input bit to, input int lat,
                                 input int limit);
        end_t e;
        if (expect_end) begin
            e.word_count = wc;
            e.sum        = DATA_W'(sum);
            e.timeout    = to;
            e.latency    = lat;
            e.limit      = limit;
            exp_ends.push_back(e);
        end
        start     = 1'b1;
        burst_len = LEN_W'(len);
        cyc(1);
        start = 1'b0;
    endtask

    task automatic waitDone(input int limit);
        for (int i = 0; i < limit; i++) begin
            cyc(1);
            if (done) break;
        end
        cyc(2);
    endtask

    // Directed sequence of bursts.
    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        burst_len  = '0;
        wr_en      = 1'b0;
        wr_data    = '0;
        ready_mode = 0;
        cyc(3);
        rst = 1'b0;
        cyc(2);

        $display("[TB] full-rate burst of 16");
        loadWords(10, 16);
        pushBeats(10, 16, 1'b1);
        applyStimulus(16, 1'b1, 16, 280, 1'b0, 19, 60);
        waitDone(70);

        $display("[TB] burst of 16 with alternating ready");
        loadWords(10, 16);
        pushBeats(10, 16, 1'b1);
        ready_mode = 1;
        applyStimulus(16, 1'b1, 16, 280, 1'b0, 0, 100);
        waitDone(110);
        ready_mode = 0;
        cyc(2);

        $display("[TB] burst of 17 with 16 words: timeout");
        loadWords(10, 16);
        pushBeats(10, 16, 1'b0);
        applyStimulus(17, 1'b1, 16, 280, 1'b1, 83, 200);
        waitDone(210);

        $display("[TB] zero-length burst");
        applyStimulus(0, 1'b1, 0, 0, 1'b0, 2, 10);
        waitDone(20);

        $display("[TB] reset after 5 beats, then burst of 11");
        loadWords(10, 16);
        pushBeats(10, 5, 1'b0);
        applyStimulus(16, 1'b0, 0, 0, 1'b0, 0, 0);
        for (int i = 0; i < 40; i++) begin
            if (word_count == LEN_W'(5)) break;
            cyc(1);
        end
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        cyc(2);
        pushBeats(16, 10, 1'b0);
        applyStimulus(11, 1'b1, 10, 205, 1'b1, 77, 200);
        waitDone(210);

        $display("[TB] start pulse while busy");
        loadWords(10, 16);
        pushBeats(10, 16, 1'b1);
        applyStimulus(16, 1'b1, 16, 280, 1'b0, 19, 60);
        cyc(4);
        start     = 1'b1;
        burst_len = LEN_W'(3);
        cyc(1);
        start = 1'b0;
        waitDone(70);

        tb_finished = 1'b1;
        cyc(3);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 check_count, error_count);
        $finish;
    end

    // Hard stop if the sequence ever stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] simulation watchdog expired");
    end

endmodule
